mem_arbiter: RTL

Three-way arbiter and sequencer for the single-port 512×32 program/data RAM behind the LSU. It shares the RAM between:
- the host loader port (external `addr`/`wEn`/`wDat` path);
- the pipeline data port (LW/SW);
- the instruction-fetch port.

It replaces the ad-hoc `wEn ? addr : pc` and `SW ? valA : wDat` muxing with a registered request/grant/response protocol.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and defaults for the RAM arbiter
// Purpose: FSM state encoding, requester port ids and default RAM geometry
//          used by mem_arbiter.
// Ports:   none (package).
package mem_pkg;

  localparam int MEM_AW = 9;   // 512-word RAM
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PORT_HOST  = 2'd0,
    PORT_DATA  = 2'd1,
    PORT_FETCH = 2'd2
  } port_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for the RAM arbiter
// Purpose: turn the three eligibility bits into a one-hot winner.
//          Host always wins; a data/fetch tie goes to data unless
//          i_prefer_fetch is set.
// Ports:   i_elig         {fetch, data, host} eligible requests
//          i_prefer_fetch tie-break toward fetch between data and fetch
//          o_win          one-hot winner, same bit order as i_elig
module mem_arb_pick (
  input  logic [2:0] i_elig,
  input  logic       i_prefer_fetch,
  output logic [2:0] o_win
);

  always_comb begin
    o_win = 3'b000;
    if (i_elig[0]) begin
      o_win = 3'b001;
    end else if (i_elig[1] && i_elig[2]) begin
      o_win = i_prefer_fetch ? 3'b100 : 3'b010;
    end else if (i_elig[1]) begin
      o_win = 3'b010;
    end else if (i_elig[2]) begin
      o_win = 3'b100;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-way arbiter/sequencer for the shared 512x32 RAM
// Purpose: grants one of host/data/fetch in IDLE, issues a single registered
//          RAM command in ISSUE and, for reads, returns the RAM data to the
//          owning port in RESP.
// Ports:   clock, reset_n           clock, async active-low reset
//          working                  low masks fetch requests
//          h_*  host port   (req/we/addr/wdata -> gnt/rvalid/rdata)
//          d_*  data port   (req/we/addr/wdata -> gnt/rvalid/rdata)
//          f_*  fetch port  (req/addr -> gnt/rvalid/rdata), read-only
//          ram_en/ram_we/ram_addr/ram_wdata  registered RAM command
//          ram_rdata                RAM data, valid the cycle after a read
//          busy                     high whenever the FSM is not in IDLE
// Macro:   MEM_ARB_RR_EN  alternate data/fetch on ties (host stays highest)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          working,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  state_t        r_state;
  port_t         r_port;
  logic          r_ram_en;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic          r_h_rvalid;
  logic          r_d_rvalid;
  logic          r_f_rvalid;
  logic [DW-1:0] r_h_rdata;
  logic [DW-1:0] r_d_rdata;
  logic [DW-1:0] r_f_rdata;

  logic [2:0]    w_elig;
  logic [2:0]    w_win;
  logic [2:0]    w_gnt;
  logic          w_prefer_fetch;

  assign w_elig = {f_req & working, d_req, h_req};

  mem_arb_pick u_pick (
    .i_elig        (w_elig),
    .i_prefer_fetch(w_prefer_fetch),
    .o_win         (w_win)
  );

  // Grant is decided in the IDLE cycle itself so the requester sees it in
  // the same cycle it is sampled; reset_n gating keeps it low during reset.
  assign w_gnt = (r_state == ST_IDLE && reset_n) ? w_win : 3'b000;

`ifdef MEM_ARB_RR_EN
  // 1 = data won the last data/fetch grant, so fetch is preferred next tie.
  logic r_last_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_data <= 1'b0;
    end else if (w_gnt[1]) begin
      r_last_data <= 1'b1;
    end else if (w_gnt[2]) begin
      r_last_data <= 1'b0;
    end
  end

  assign w_prefer_fetch = r_last_data;
`else
  assign w_prefer_fetch = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_port      <= PORT_HOST;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_h_rvalid  <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_f_rvalid  <= 1'b0;
      r_h_rdata   <= '0;
      r_d_rdata   <= '0;
      r_f_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_state  <= ST_ISSUE;
            r_ram_en <= 1'b1;
            if (w_gnt[0]) begin
              r_port      <= PORT_HOST;
              r_ram_we    <= h_we;
              r_ram_addr  <= h_addr;
              r_ram_wdata <= h_wdata;
            end else if (w_gnt[1]) begin
              r_port      <= PORT_DATA;
              r_ram_we    <= d_we;
              r_ram_addr  <= d_addr;
              r_ram_wdata <= d_wdata;
            end else begin
              r_port      <= PORT_FETCH;
              r_ram_we    <= 1'b0;
              r_ram_addr  <= f_addr;
              r_ram_wdata <= '0;
            end
          end
        end
        ST_ISSUE: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_ram_we) begin
            r_state <= ST_IDLE;
          end else begin
            r_state    <= ST_RESP;
            r_h_rvalid <= (r_port == PORT_HOST);
            r_d_rvalid <= (r_port == PORT_DATA);
            r_f_rvalid <= (r_port == PORT_FETCH);
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          r_h_rvalid <= 1'b0;
          r_d_rvalid <= 1'b0;
          r_f_rvalid <= 1'b0;
          if (r_h_rvalid) r_h_rdata <= ram_rdata;
          if (r_d_rvalid) r_d_rdata <= ram_rdata;
          if (r_f_rvalid) r_f_rdata <= ram_rdata;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign h_gnt     = w_gnt[0];
  assign d_gnt     = w_gnt[1];
  assign f_gnt     = w_gnt[2];
  assign h_rvalid  = r_h_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign f_rvalid  = r_f_rvalid;
  // RAM data is only valid during RESP, so the owner sees it live and the
  // holding register takes it over at the end of that cycle.
  assign h_rdata   = r_h_rvalid ? ram_rdata : r_h_rdata;
  assign d_rdata   = r_d_rvalid ? ram_rdata : r_d_rdata;
  assign f_rdata   = r_f_rvalid ? ram_rdata : r_f_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign busy      = (r_state != ST_IDLE);

endmodule
